qea_host_loader: RTL and testbench

Host-side sequencer that drives the QEA load/start/readback ports from streams.
- Accepts one input stream: gate-context words, then state amplitudes.
- Writes them into QEA context and state RAMs, pulses start, waits for completion.
- Reads the state RAM back and emits amplitudes on an output stream.
- Sits between a host DMA/UART bridge and the QEA instance, replacing hand-written bench load loops.

---
 rtl/qea_loader_pkg.sv | 21 ++
 rtl/qea_lane_packer.sv | 53 +++++
 rtl/qea_host_loader.sv | 202 ++++++++++++++++++++
 tb/tb_qea_host_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qea_loader_pkg.sv
// Shared definitions for the QEA host loader: FSM encoding, amplitude lane width,
// read-latency bound and the qubit-count validity rule.
package qea_loader_pkg;

    localparam int AMP_W      = 64;
    localparam int RD_LAT_MAX = 4;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LOAD_CTX   = 3'd1;
    localparam logic [2:0] ST_LOAD_STATE = 3'd2;
    localparam logic [2:0] ST_START      = 3'd3;
    localparam logic [2:0] ST_RUN        = 3'd4;
    localparam logic [2:0] ST_READ       = 3'd5;
    localparam logic [2:0] ST_DRAIN      = 3'd6;
    localparam logic [2:0] ST_DONE       = 3'd7;

    function automatic logic qbit_ok(input int n, input int pe_w, input int sa_w);
        return (n >= pe_w) && (n - pe_w <= sa_w);
    endfunction

endpackage

// File: rtl/qea_lane_packer.sv
// Lane buffer: serial amplitudes to a packed state word on load, packed word back to serial on drain.
// Latency: packed word available combinationally with the last lane; drain data follows the lane counter.
// Backpressure: advances only on ld_vld / drn_adv, so stalled callers see stable drn_dat.
module qea_lane_packer
    import qea_loader_pkg::*;
#(
    parameter int PE_NUM_WIDTH = 2,
    parameter int PE_NUM       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_vld,
    input  logic [AMP_W-1:0]        ld_dat,
    input  logic                    cap_vld,
    input  logic [PE_NUM*AMP_W-1:0] cap_dat,
    input  logic                    drn_adv,
    output logic                    lane_last,
    output logic [PE_NUM*AMP_W-1:0] pack_dat,
    output logic [AMP_W-1:0]        drn_dat
);

    logic [AMP_W-1:0]        lanes [PE_NUM];
    logic [PE_NUM_WIDTH-1:0] lane_cnt;

    assign lane_last = (lane_cnt == PE_NUM_WIDTH'(PE_NUM - 1));
    assign drn_dat   = lanes[lane_cnt];

    // The lane being written this cycle comes straight from the input so the
    // final handshake can be committed to RAM without an extra cycle.
    always_comb begin
        pack_dat = '0;
        for (int j = 0; j < PE_NUM; j++)
            pack_dat[(PE_NUM-j)*AMP_W-1 -: AMP_W] = (lane_cnt == PE_NUM_WIDTH'(j)) ? ld_dat : lanes[j];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt <= '0;
            for (int j = 0; j < PE_NUM; j++)
                lanes[j] <= '0;
        end else if (cap_vld) begin
            lane_cnt <= '0;
            for (int j = 0; j < PE_NUM; j++)
                lanes[j] <= cap_dat[(PE_NUM-j)*AMP_W-1 -: AMP_W];
        end else if (ld_vld) begin
            lanes[lane_cnt] <= ld_dat;
            lane_cnt        <= lane_cnt + PE_NUM_WIDTH'(1);
        end else if (drn_adv) begin
            lane_cnt <= lane_cnt + PE_NUM_WIDTH'(1);
        end
    end

endmodule

// File: rtl/qea_host_loader.sv
// Host sequencer: streams context + amplitudes into QEA, starts it, streams amplitudes back (QEA_LOADER_CYCLE_CNT_EN adds o_cycles).
// Latency: RAM strobes registered one cycle after each handshake; readback is RD_LAT+1 cycles per address.
// Backpressure: s_ready only in load states; m_valid/m_data held while m_ready is low.
module qea_host_loader
    import qea_loader_pkg::*;
#(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int RD_LAT                  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [63:0]                          s_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [63:0]                          m_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err,
    output logic [31:0]                          o_cycles,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    output logic                                 o_start,
    input  logic                                 i_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout
);

    localparam int AW1 = STATE_ADDR_WIDTH + 1;

    logic [2:0]                         state;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_cnt;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_nxt;
    logic [AW1-1:0]                     addr_cnt;
    logic [AW1-1:0]                     addr_nxt;
    logic [AW1-1:0]                     addr_num;
    logic [2:0]                         rd_cnt;
    logic                               s_hs;
    logic                               m_hs;
    logic                               go_ok;
    logic                               lane_last;
    logic                               cap_vld;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0] pack_dat;
    logic [63:0]                        drn_dat;

    assign s_ready  = (state == ST_LOAD_CTX) || (state == ST_LOAD_STATE);
    assign m_valid  = (state == ST_DRAIN);
    assign s_hs     = s_valid && s_ready;
    assign m_hs     = m_valid && m_ready;
    assign m_data   = m_valid ? drn_dat : '0;
    assign o_start  = (state == ST_START);
    assign o_done   = (state == ST_DONE);
    assign o_busy   = (state != ST_IDLE) && (state != ST_DONE);
    assign go_ok    = qbit_ok(int'(i_qbit_num), PE_NUM_WIDTH, STATE_ADDR_WIDTH);
    assign ctx_nxt  = ctx_cnt + GATE_CONTEXT_ADDR_WIDTH'(1);
    assign addr_nxt = addr_cnt + AW1'(1);
    assign cap_vld  = (state == ST_READ) && (rd_cnt == 3'(RD_LAT));

    qea_lane_packer #(
        .PE_NUM_WIDTH (PE_NUM_WIDTH),
        .PE_NUM       (PE_NUM)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .ld_vld    (s_hs && (state == ST_LOAD_STATE)),
        .ld_dat    (s_data),
        .cap_vld   (cap_vld),
        .cap_dat   (i_state_dout),
        .drn_adv   (m_hs),
        .lane_last (lane_last),
        .pack_dat  (pack_dat),
        .drn_dat   (drn_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ins_q         <= '0;
            ctx_cnt       <= '0;
            addr_cnt      <= '0;
            addr_num      <= '0;
            rd_cnt        <= '0;
            o_err         <= 1'b0;
            o_ctx_en      <= 1'b0;
            o_ctx_wea     <= 1'b0;
            o_ctx_addr    <= '0;
            o_ctx_data    <= '0;
            o_state_ena   <= 1'b0;
            o_state_wea   <= 1'b0;
            o_state_addra <= '0;
            o_state_dina  <= '0;
        end else begin
            o_err       <= 1'b0;
            o_ctx_en    <= 1'b0;
            o_ctx_wea   <= 1'b0;
            o_state_ena <= 1'b0;
            o_state_wea <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_go && go_ok) begin
                        ins_q    <= i_ins_num;
                        ctx_cnt  <= '0;
                        addr_cnt <= '0;
                        addr_num <= AW1'(1) << (i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH));
                        state    <= (i_ins_num == '0) ? ST_LOAD_STATE : ST_LOAD_CTX;
                    end else if (i_go) begin
                        o_err <= 1'b1;
                    end
                end
                ST_LOAD_CTX: begin
                    if (s_hs) begin
                        o_ctx_en   <= 1'b1;
                        o_ctx_wea  <= 1'b1;
                        o_ctx_addr <= ctx_cnt;
                        o_ctx_data <= GATE_CONTEXT_DATA_WIDTH'(s_data);
                        ctx_cnt    <= ctx_nxt;
                        if (ctx_nxt == ins_q)
                            state <= ST_LOAD_STATE;
                    end
                end
                ST_LOAD_STATE: begin
                    if (s_hs && lane_last) begin
                        o_state_ena   <= 1'b1;
                        o_state_wea   <= 1'b1;
                        o_state_addra <= addr_cnt[STATE_ADDR_WIDTH-1:0];
                        o_state_dina  <= pack_dat;
                        addr_cnt      <= addr_nxt;
                        if (addr_nxt == addr_num)
                            state <= ST_START;
                    end
                end
                ST_START: begin
                    addr_cnt <= '0;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (i_complete) begin
                        o_state_ena   <= 1'b1;
                        o_state_addra <= addr_cnt[STATE_ADDR_WIDTH-1:0];
                        rd_cnt        <= '0;
                        state         <= ST_READ;
                    end
                end
                ST_READ: begin
                    rd_cnt <= rd_cnt + 3'd1;
                    if (cap_vld) begin
                        addr_cnt <= addr_nxt;
                        state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // addr_cnt already points past the address being drained.
                    if (m_hs && lane_last) begin
                        if (addr_cnt == addr_num) begin
                            state <= ST_DONE;
                        end else begin
                            o_state_ena   <= 1'b1;
                            o_state_addra <= addr_cnt[STATE_ADDR_WIDTH-1:0];
                            rd_cnt        <= '0;
                            state         <= ST_READ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef QEA_LOADER_CYCLE_CNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk) begin
        if (rst)
            cyc_q <= '0;
        else if (state == ST_START)
            cyc_q <= '0;
        else if (state == ST_RUN)
            cyc_q <= cyc_q + 32'd1;
    end

    assign o_cycles = cyc_q;
`else
    assign o_cycles = '0;
`endif

endmodule

// File: tb/tb_qea_host_loader.sv
// Randomized directed bench for qea_host_loader with a behavioural QEA RAM/completion model.
module tb_qea_host_loader;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_go;
    logic [5:0]    i_qbit_num;
    logic [15:0]   i_ins_num;
    logic          s_valid;
    logic          s_ready;
    logic [63:0]   s_data;
    logic          m_valid;
    logic          m_ready;
    logic [63:0]   m_data;
    logic          o_busy, o_done, o_err;
    logic [31:0]   o_cycles;
    logic          o_ctx_en, o_ctx_wea;
    logic [15:0]   o_ctx_addr;
    logic [63:0]   o_ctx_data;
    logic          o_state_ena, o_state_wea;
    logic [15:0]   o_state_addra;
    logic [255:0]  o_state_dina;
    logic          o_start;
    logic          i_complete;
    logic [255:0]  i_state_dout;

    qea_host_loader dut (
        .clk(clk), .rst(rst), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_cycles(o_cycles),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .o_start(o_start), .i_complete(i_complete),
        .i_state_dout(i_state_dout)
    );

    always #5 clk = ~clk;

`ifdef QEA_LOADER_CYCLE_CNT_EN
    localparam int EXP_CYCLES = 50;
`else
    localparam int EXP_CYCLES = 0;
`endif

    int checks = 0;
    int failures = 0;

    int           ctx_addr_q[$];
    logic [63:0]  ctx_dat_q[$];
    int           st_addr_q[$];
    logic [255:0] st_dat_q[$];
    logic [255:0] mem [int];
    logic [63:0]  tx_q[$];
    logic [63:0]  amps_q[$];
    logic [63:0]  rx_q[$];
    int start_cnt = 0, err_cnt = 0, busy_cnt = 0, strobe_cnt = 0;
    bit rd_pend = 0;
    int rd_addr = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // QEA side: RAM with one cycle read latency plus write/strobe bookkeeping.
    initial begin
        i_state_dout = '0;
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                i_state_dout = mem.exists(rd_addr) ? mem[rd_addr] : '0;
                rd_pend = 0;
            end
            if (!rst) begin
                if (o_ctx_en && o_ctx_wea) begin
                    ctx_addr_q.push_back(int'(o_ctx_addr));
                    ctx_dat_q.push_back(o_ctx_data);
                end
                if (o_state_ena && o_state_wea) begin
                    st_addr_q.push_back(int'(o_state_addra));
                    st_dat_q.push_back(o_state_dina);
                    mem[int'(o_state_addra)] = o_state_dina;
                end
                if (o_state_ena && !o_state_wea) begin
                    rd_pend = 1;
                    rd_addr = int'(o_state_addra);
                end
                if (o_start) start_cnt++;
                if (o_err) err_cnt++;
                if (o_busy) busy_cnt++;
                if (o_ctx_en || o_state_ena || o_start) strobe_cnt++;
            end
        end
    end

    // QEA completion: level stays high from the previous job through the START edge, then
    // drops and rises again 50 cycles after start.
    initial begin
        i_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (o_start) begin
                @(posedge clk);
                #1 i_complete = 1'b0;
                repeat (49) @(posedge clk);
                #1 i_complete = 1'b1;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] pack(input int a);
        logic [255:0] p;
        for (int j = 0; j < 4; j++)
            p[(4-j)*64-1 -: 64] = amps_q[4*a+j];
        return p;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy_rdy_vld"}, {o_busy, s_ready, m_valid, o_done, o_err, o_start}, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_cycles"}, o_cycles, 0);
        check({tag, "_ctx"}, {o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data}, 0);
        check({tag, "_st_ctl"}, {o_state_ena, o_state_wea, o_state_addra}, 0);
        check({tag, "_st_dina"}, o_state_dina, 0);
    endtask

    task automatic send_words(input int cnt);
        int idx = 0;
        for (int cyc = 0; cyc < 20000 && idx < cnt; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = tx_q[idx];
            end
            if (s_valid && s_ready) idx++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        check("send_count", idx, cnt);
    endtask

    // mode 0: m_ready always high, 1: toggling every cycle, 2: random
    task automatic collect(input int num, input int mode);
        bit phase = 1'b1;
        bit prev_stall = 1'b0;
        logic [63:0] prev_dat = '0;
        rx_q.delete();
        for (int cyc = 0; cyc < 8000 && rx_q.size() < num; cyc++) begin
            @(negedge clk);
            m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? phase : 1'($urandom_range(0, 1));
            phase = ~phase;
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_dat);
            end
            if (m_valid && m_ready) rx_q.push_back(m_data);
            prev_stall = m_valid && !m_ready;
            prev_dat   = m_data;
        end
        check("rx_count", rx_q.size(), num);
    endtask

    task automatic run_job(input int n, input int ins, input int mode, input bit plan);
        int a  = 1 << (n - 2);
        int na = 4 * a;
        int s0, e0;
        bit seen_done = 0;
        tx_q.delete(); amps_q.delete();
        ctx_addr_q.delete(); ctx_dat_q.delete(); st_addr_q.delete(); st_dat_q.delete();
        for (int k = 0; k < ins; k++) tx_q.push_back({$urandom, $urandom});
        for (int k = 0; k < na; k++) begin
            if (plan) amps_q.push_back((k == 0) ? 64'h40000000_00000000 : 64'h0);
            else      amps_q.push_back({$urandom, $urandom});
            tx_q.push_back(amps_q[k]);
        end
        s0 = start_cnt; e0 = err_cnt;
        @(negedge clk);
        i_qbit_num = 6'(n); i_ins_num = 16'(ins); i_go = 1'b1;
        @(negedge clk);
        i_go = 1'b0;
        check("busy_after_go", o_busy, 1);
        i_qbit_num = 6'd1; i_go = 1'b1;     // ignored while busy
        @(negedge clk);
        i_go = 1'b0;
        send_words(ins + na);
        collect(na, mode);
        for (int k = 0; k < 20 && !seen_done; k++) begin
            @(negedge clk);
            if (o_done) seen_done = 1;
        end
        check("done_seen", seen_done, 1);
        check("done_busy", o_busy, 0);
        check("cycles", o_cycles, EXP_CYCLES);
        m_ready = 1'b0;
        @(negedge clk);
        check("done_pulse_end", o_done, 0);
        check("start_pulses", start_cnt - s0, 1);
        check("no_err_busy_go", err_cnt - e0, 0);
        check("ctx_count", ctx_addr_q.size(), ins);
        for (int k = 0; k < ctx_addr_q.size() && k < ins; k++) begin
            check("ctx_addr", ctx_addr_q[k], k);
            check("ctx_data", ctx_dat_q[k], tx_q[k]);
        end
        check("st_count", st_addr_q.size(), a);
        for (int k = 0; k < st_addr_q.size() && k < a; k++) begin
            check("st_addr", st_addr_q[k], k);
            check("st_dina", st_dat_q[k], pack(k));
        end
        for (int k = 0; k < rx_q.size() && k < na; k++)
            check("rx_word", rx_q[k], amps_q[k]);
    endtask

    task automatic err_job(input int n);
        int e0 = err_cnt;
        int s0 = strobe_cnt;
        int b0 = busy_cnt;
        @(negedge clk);
        i_qbit_num = 6'(n); i_ins_num = 16'd3; i_go = 1'b1;
        @(negedge clk);
        i_go = 1'b0;
        check("err_pulse", o_err, 1);
        check("err_busy", o_busy, 0);
        repeat (4) @(negedge clk);
        check("err_once", err_cnt - e0, 1);
        check("err_no_strobe", strobe_cnt - s0, 0);
        check("err_never_busy", busy_cnt - b0, 0);
        check("err_s_ready", s_ready, 0);
    endtask

    initial begin
        rst = 1'b1; i_go = 1'b0; i_qbit_num = '0; i_ins_num = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run_job(4, 105, 0, 1'b1);
        run_job(3, 7, 1, 1'b0);
        err_job(1);
        err_job(63);
        err_job(0);
        run_job(2, 0, 1, 1'b0);

        // Abort in LOAD_STATE after 2 context words and 6 amplitudes.
        tx_q.delete(); st_addr_q.delete(); ctx_addr_q.delete(); ctx_dat_q.delete(); st_dat_q.delete();
        for (int k = 0; k < 18; k++) tx_q.push_back({$urandom, $urandom});
        @(negedge clk);
        i_qbit_num = 6'd4; i_ins_num = 16'd2; i_go = 1'b1;
        @(negedge clk);
        i_go = 1'b0;
        send_words(8);
        check("abort_ctx_writes", ctx_addr_q.size(), 2);
        check("abort_st_writes", st_addr_q.size(), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 check_zero("midjob_rst");
        @(negedge clk);
        rst = 1'b0;

        run_job(4, 3, 2, 1'b0);
        run_job(5, 20, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
